// File: rtl/lcd_panel_rx.sv
// lcd_panel_rx: panel-side receiver for the LCD controller output. Recovers frame/line timing,
// tags pixels with x/y and checks geometry. Optional frame CRC-16 when LCD_RX_CRC_EN is defined.
module lcd_panel_rx #(
    parameter int unsigned DW  = 24,
    parameter int unsigned XW  = 11,
    parameter int unsigned YW  = 10,
    parameter int unsigned FCW = 16
) (
    input  logic           HCLK,
    input  logic           HRESET,
    input  logic           rx_en,
    input  logic           cfg_tft,
    input  logic [XW-1:0]  cfg_ppl,
    input  logic [YW-1:0]  cfg_lpp,
    input  logic           lcd_fp,
    input  logic           lcd_lp,
    input  logic           lcd_dclk,
    input  logic           lcd_ena,
    input  logic [DW-1:0]  lcd_vd,
    output logic           pix_valid,
    output logic [DW-1:0]  pix_data,
    output logic [XW-1:0]  pix_x,
    output logic [YW-1:0]  pix_y,
    output logic           sof,
    output logic           eol,
    output logic [FCW-1:0] frame_cnt,
    output logic [XW-1:0]  hsw_meas,
    output logic           err_ppl,
    output logic           err_lpp,
    output logic [15:0]    frame_crc
);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBLANK, S_HSYNC, S_HBP, S_ACTIVE, S_HFP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_fp_q, r_lp_q, r_dclk_q, r_ena_q;
    logic [XW-1:0]   r_x, r_hsw;
    logic [YW-1:0]   r_y, w_y_inc, w_y_acc;
    logic            w_fp_rise, w_fp_fall, w_lp_rise, w_lp_fall, w_dclk_rise, w_ena_rise, w_ena_fall;
    logic            w_cap, w_eol, w_start, w_frame_end, w_trunc;
    logic            w_hs_start, w_hs_end, w_line_start;
    logic [DW-1:0]   w_pix;

    assign w_fp_rise   =  lcd_fp   & ~r_fp_q;
    assign w_fp_fall   = ~lcd_fp   &  r_fp_q;
    assign w_lp_rise   =  lcd_lp   & ~r_lp_q;
    assign w_lp_fall   = ~lcd_lp   &  r_lp_q;
    assign w_dclk_rise =  lcd_dclk & ~r_dclk_q;
    assign w_ena_rise  =  lcd_ena  & ~r_ena_q;
    assign w_ena_fall  = ~lcd_ena  &  r_ena_q;

    assign w_pix   = cfg_tft ? lcd_vd : DW'(lcd_vd[15:0]);
    assign w_y_inc = (r_y == {YW{1'b1}}) ? r_y : r_y + YW'(1);
    // Line accounting on this cycle's eol is visible to a coincident frame end
    assign w_y_acc = w_eol ? w_y_inc : r_y;

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cap        = 1'b0;
        w_eol        = 1'b0;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        w_trunc      = 1'b0;
        w_hs_start   = 1'b0;
        w_hs_end     = 1'b0;
        w_line_start = 1'b0;
        if (!rx_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (w_fp_rise) begin w_state_nxt = S_VSYNC; w_start = 1'b1; end
                S_VSYNC:  if (w_fp_fall) w_state_nxt = S_VBLANK;
                S_VBLANK: if (w_lp_rise) begin w_state_nxt = S_HSYNC; w_hs_start = 1'b1; end
                S_HSYNC:  if (w_lp_fall) begin w_state_nxt = S_HBP; w_hs_end = 1'b1; end
                S_HBP:    if (w_ena_rise) begin w_state_nxt = S_ACTIVE; w_line_start = 1'b1; end
                S_ACTIVE: begin
                    w_cap = w_dclk_rise & lcd_ena;
                    if (w_ena_fall) begin w_state_nxt = S_HFP; w_eol = 1'b1; end
                end
                S_HFP:    if (w_lp_rise) begin w_state_nxt = S_HSYNC; w_hs_start = 1'b1; end
                default:  w_state_nxt = S_IDLE;
            endcase
            // Frame pulse from any tracking state closes the frame; outside blanking it is truncated
            if (r_state != S_IDLE && w_fp_rise) begin
                w_state_nxt = S_VSYNC;
                w_frame_end = 1'b1;
                w_hs_start  = 1'b0;
                w_trunc     = !(r_state == S_HFP || r_state == S_VBLANK ||
                                (r_state == S_ACTIVE && w_ena_fall));
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_fp_q    <= 1'b0;
            r_lp_q    <= 1'b0;
            r_dclk_q  <= 1'b0;
            r_ena_q   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_hsw     <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= '0;
            hsw_meas  <= '0;
            err_ppl   <= 1'b0;
            err_lpp   <= 1'b0;
        end else begin
            r_fp_q    <= lcd_fp;
            r_lp_q    <= lcd_lp;
            r_dclk_q  <= lcd_dclk;
            r_ena_q   <= lcd_ena;
            pix_valid <= w_cap;
            sof       <= w_start | w_frame_end;
            eol       <= w_eol;

            if (w_cap) begin
                pix_data <= w_pix;
                pix_x    <= r_x;
                pix_y    <= r_y;
                if (r_x != {XW{1'b1}}) r_x <= r_x + XW'(1);
            end
            if (w_line_start) r_x <= '0;

            if (w_hs_start) r_hsw <= XW'(1);
            else if (r_state == S_HSYNC && lcd_lp && r_hsw != {XW{1'b1}}) r_hsw <= r_hsw + XW'(1);
            if (w_hs_end) hsw_meas <= r_hsw;

            if (w_eol) begin
                r_y <= w_y_inc;
                if (r_x != cfg_ppl) err_ppl <= 1'b1;
            end

            if (w_frame_end) begin
                frame_cnt <= frame_cnt + FCW'(1);
                if (w_trunc || w_y_acc != cfg_lpp) err_lpp <= 1'b1;
            end
            if (w_start || w_frame_end) r_y <= '0;

            if (!rx_en) begin
                r_x   <= '0;
                r_y   <= '0;
                r_hsw <= '0;
            end
        end
    end

`ifdef LCD_RX_CRC_EN
    // CRC-16-CCITT, MSB first, one pixel word per step
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] d);
        logic [15:0] v;
        v = c;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ 16'h1021;
            else              v = {v[14:0], 1'b0};
        end
        return v;
    endfunction

    logic [15:0] r_crc, w_crc_acc;

    assign w_crc_acc = w_cap ? crc_step(r_crc, w_pix) : r_crc;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_crc     <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else begin
            if (w_start || w_frame_end) r_crc <= 16'hFFFF;
            else                        r_crc <= w_crc_acc;
            if (w_frame_end) frame_crc <= w_crc_acc;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule
